// File: rtl/fft_pkg.sv
// Shared FFT datapath constants: component width, lanes per beat, beats per frame.
// Also used by the per-stage coefficient ROMs, so FRAC and the rounding constant live here.
// Pure declarations, no logic.
package fft_pkg;

    localparam int NBITS = 11;
    localparam int N     = 32;
    localparam int BEATS = 4;

    // Twiddles are Q1.FRAC, so 1.0 = 2^FRAC.
    localparam int FRAC  = NBITS - 2;

    // Adding half an LSB before the shift gives round-half-up.
    function automatic int rnd_const(input int frac);
        return 1 << (frac - 1);
    endfunction

    localparam int RND   = rnd_const(FRAC);

    // Width of a counter that counts 0..beats-1. A single-beat frame still gets one bit.
    function automatic int cnt_w(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/twiddle_mult_stage_cmul_lane.sv
// cmul_lane: one lane's complex multiply by a twiddle, then round-half-up and narrow to NBITS.
// Latency 2 cycles: products are registered on ld1, and the rounded sums are registered on ld2.
// Backpressure: no handshake here; the parent holds ld1/ld2 low to freeze both registers.
// Optional TWMUL_SAT_EN: narrowing saturates instead of wrapping.
module cmul_lane #(
    parameter int NBITS = 11,
    parameter int FRAC  = NBITS - 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ld1,
    input  logic                 ld2,
    input  logic [2*NBITS-1:0]   in_lane,
    input  logic [2*NBITS-1:0]   coeff_lane,
    output logic [2*NBITS-1:0]   out_lane
);
    import fft_pkg::*;

    localparam int PW = 2 * NBITS;      // full product width
    localparam int SW = 2 * NBITS + 1;  // sum width, one guard bit above the products

    typedef logic signed [PW-1:0] prod_t;
    typedef logic signed [SW-1:0] sum_t;

    localparam sum_t RND_S = sum_t'(rnd_const(FRAC));
`ifdef TWMUL_SAT_EN
    localparam sum_t SAT_MAX = sum_t'((1 <<< (NBITS - 1)) - 1);
    localparam sum_t SAT_MIN = sum_t'(-(1 <<< (NBITS - 1)));
`endif

    logic signed [NBITS-1:0] dr, di, cr, ci;
    prod_t p_rr_q, p_rr_d;   // dr*cr
    prod_t p_ii_q, p_ii_d;   // di*ci
    prod_t p_ri_q, p_ri_d;   // dr*ci
    prod_t p_ir_q, p_ir_d;   // di*cr
    sum_t  sum_re, sum_im;
    logic [2*NBITS-1:0] out_q, out_d;

    assign dr = in_lane[2*NBITS-1:NBITS];
    assign di = in_lane[NBITS-1:0];
    assign cr = coeff_lane[2*NBITS-1:NBITS];
    assign ci = coeff_lane[NBITS-1:0];

    // Round the full-precision sum, then narrow it (wrap by default, or clamp when saturation is enabled).
    function automatic logic [NBITS-1:0] narrow(input sum_t s);
        sum_t r;
        r = (s + RND_S) >>> FRAC;
`ifdef TWMUL_SAT_EN
        if (r > SAT_MAX) begin
            r = SAT_MAX;
        end else if (r < SAT_MIN) begin
            r = SAT_MIN;
        end
`endif
        return NBITS'(r);
    endfunction

    // Stage 1 next state: capture the four full-width partial products.
    always_comb begin
        p_rr_d = p_rr_q;
        p_ii_d = p_ii_q;
        p_ri_d = p_ri_q;
        p_ir_d = p_ir_q;
        if (ld1) begin
            p_rr_d = PW'(dr) * PW'(cr);
            p_ii_d = PW'(di) * PW'(ci);
            p_ri_d = PW'(dr) * PW'(ci);
            p_ir_d = PW'(di) * PW'(cr);
        end
    end

    // Stage 2 next state: combine the products at full width, then round and narrow once.
    always_comb begin
        sum_re = SW'(p_rr_q) - SW'(p_ii_q);
        sum_im = SW'(p_ri_q) + SW'(p_ir_q);
        out_d  = out_q;
        if (ld2) begin
            out_d = {narrow(sum_re), narrow(sum_im)};
        end
    end

    // Pipeline registers; reset clears the output so an idle stage presents zeros.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_rr_q <= '0;
            p_ii_q <= '0;
            p_ri_q <= '0;
            p_ir_q <= '0;
            out_q  <= '0;
        end else begin
            p_rr_q <= p_rr_d;
            p_ii_q <= p_ii_d;
            p_ri_q <= p_ri_d;
            p_ir_q <= p_ir_d;
            out_q  <= out_d;
        end
    end

    assign out_lane = out_q;

endmodule

// File: rtl/twiddle_mult_stage.sv
// twiddle_mult_stage: multiplies N complex lanes per beat by their twiddles and tags each frame's last beat.
// Latency 2 cycles; one beat per cycle, even when a beat is accepted and another leaves in the same cycle.
// Backpressure: the whole pipe advances only when en = !out_valid || out_ready, and in_ready = en.
// Optional TWMUL_SAT_EN (handled in cmul_lane): results saturate instead of wrapping.
module twiddle_mult_stage #(
    parameter int NBITS = fft_pkg::NBITS,
    parameter int N     = fft_pkg::N,
    parameter int BEATS = fft_pkg::BEATS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NBITS*N*2-1:0] in_data,
    input  logic [NBITS*N*2-1:0] coeff_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NBITS*N*2-1:0] out_data,
    output logic                 out_last
);
    import fft_pkg::*;

    localparam int LW = 2 * NBITS;
    localparam int CW = cnt_w(BEATS);
    localparam logic [CW-1:0] LAST_IDX = CW'(BEATS - 1);

    logic          en;
    logic          v1_q, v1_d;       // stage-1 products hold a real beat
    logic          v2_q, v2_d;       // stage-2 result holds a real beat (drives out_valid)
    logic [CW-1:0] count_q, count_d; // index of the beat now at the output within its frame
    logic          ld1, ld2;

    // The stall is global: the stage 1 and stage 2 registers move together or hold together.
    assign en       = !v2_q || out_ready;
    assign in_ready = en;
    // Registers load only when a real beat moves in, which keeps bubbles from toggling the datapath.
    assign ld1      = en && in_valid;
    assign ld2      = en && v1_q;

    // Next state for the valid flags: a bubble enters stage 1 as a cleared flag and shifts along.
    always_comb begin
        v1_d = v1_q;
        v2_d = v2_q;
        if (en) begin
            v1_d = in_valid;
            v2_d = v1_q;
        end
    end

    // Frame beat counter: advances once per output transfer and wraps at the end of the frame.
    always_comb begin
        count_d = count_q;
        if (v2_q && out_ready) begin
            count_d = (count_q == LAST_IDX) ? '0 : count_q + CW'(1);
        end
    end

    // Control state registers; reset discards in-flight beats and restarts the frame at index 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            count_q <= '0;
        end else begin
            v1_q    <= v1_d;
            v2_q    <= v2_d;
            count_q <= count_d;
        end
    end

    assign out_valid = v2_q;
    assign out_last  = v2_q && (count_q == LAST_IDX);

    // Instantiate one datapath per lane; every lane shares the pipeline load enables.
    for (genvar k = 0; k < N; k++) begin : g_lane
        cmul_lane #(
            .NBITS (NBITS),
            .FRAC  (NBITS - 2)
        ) u_lane (
            .clk        (clk),
            .rst        (rst),
            .ld1        (ld1),
            .ld2        (ld2),
            .in_lane    (in_data   [k*LW +: LW]),
            .coeff_lane (coeff_data[k*LW +: LW]),
            .out_lane   (out_data  [k*LW +: LW])
        );
    end

endmodule

// File: tb/tb_twiddle_mult_stage.sv
// Bench for twiddle_mult_stage: directed vector table, handshake corner sequences, randomized traffic.
// A scoreboard compares every output transfer with an integer-arithmetic reference model.
// Optional TWMUL_SAT_EN selects the saturating reference, matching the RTL build.
module tb_twiddle_mult_stage;

    localparam int NB = 11;
    localparam int NL = 32;
    localparam int BT = 4;
    localparam int W  = 2 * NB * NL;
    localparam int LW = 2 * NB;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic [W-1:0] coeff_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_last;

    int n_chk  = 0;
    int n_fail = 0;

    logic [W-1:0] exp_q[$];
    int out_idx = 0;
    int out_cnt = 0;

    twiddle_mult_stage dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .coeff_data (coeff_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference for one component: real-valued product scaled by 2^-9, floor(x + 1/2), then narrowed.
    function automatic int ref_comp(input int s);
        int t;
        t = s + 256;
        if (t >= 0) t = t / 512;
        else        t = -((-t + 511) / 512);
`ifdef TWMUL_SAT_EN
        if (t > 1023)  t = 1023;
        if (t < -1024) t = -1024;
`else
        t = ((t % 2048) + 2048) % 2048;
        if (t >= 1024) t = t - 2048;
`endif
        return t;
    endfunction

    function automatic logic [W-1:0] model(input logic [W-1:0] d, input logic [W-1:0] c);
        logic [W-1:0] r;
        int dr, di, cr, ci, re, im;
        r = '0;
        for (int k = 0; k < NL; k++) begin
            dr = int'($signed(d[k*LW+NB +: NB]));
            di = int'($signed(d[k*LW    +: NB]));
            cr = int'($signed(c[k*LW+NB +: NB]));
            ci = int'($signed(c[k*LW    +: NB]));
            re = ref_comp(dr * cr - di * ci);
            im = ref_comp(dr * ci + di * cr);
            r[k*LW+NB +: NB] = re[NB-1:0];
            r[k*LW    +: NB] = im[NB-1:0];
        end
        return r;
    endfunction

    function automatic logic [W-1:0] splat(input int re, input int im);
        logic [W-1:0] b;
        for (int k = 0; k < NL; k++) begin
            b[k*LW+NB +: NB] = re[NB-1:0];
            b[k*LW    +: NB] = im[NB-1:0];
        end
        return b;
    endfunction

    function automatic logic [W-1:0] rand_bus();
        logic [W-1:0] b;
        for (int i = 0; i < W / 32; i++) b[i*32 +: 32] = $urandom;
        return b;
    endfunction

    // Scoreboard: sampled mid-cycle, so it sees exactly the transfers the next rising edge performs.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out", {{(W-1){1'b0}}, out_valid}, '0);
                end else begin
                    chk("sb_data", out_data, exp_q.pop_front());
                    chk("sb_last", {{(W-1){1'b0}}, out_last},
                        {{(W-1){1'b0}}, (out_idx == BT - 1)});
                end
                out_idx = (out_idx + 1) % BT;
                out_cnt++;
            end
            if (in_valid && in_ready) exp_q.push_back(model(in_data, coeff_data));
        end
    end

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        exp_q.delete();
        out_idx  = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    typedef struct {
        string nm;
        int dr, di, cr, ci;
        int er, ei;
    } vec_t;
    vec_t tbl[8];

    initial begin
        int base;
        int sent;
        int cyc;

        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, sent, cyc;
        logic acc;

        tbl[0] = '{"unity",      100,  -50,  512,    0,  100,  -50};
        tbl[1] = '{"rot45",      512,    0,  362, -363,  362, -363};
`ifdef TWMUL_SAT_EN
        tbl[2] = '{"ovf_pos",   1023, 1023,  362,  362,    0, 1023};
        tbl[3] = '{"neg_one",  -1024,    5, -512,    0, 1023,   -5};
        tbl[4] = '{"ovf_neg",  -1024,-1024,  362, -362,-1024,    0};
`else
        tbl[2] = '{"ovf_pos",   1023, 1023,  362,  362,    0, -601};
        tbl[3] = '{"neg_one",  -1024,    5, -512,    0,-1024,   -5};
        tbl[4] = '{"ovf_neg",  -1024,-1024,  362, -362,  600,    0};
`endif
        tbl[5] = '{"half_up_p",    1,    0,  256,    0,    1,    0};
        tbl[6] = '{"half_up_n",   -1,    0,  256,    0,    0,    0};
        tbl[7] = '{"times_j",      3,   -3,    0,  512,    3,    3};

        rst        = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        in_data    = '0;
        coeff_data = '0;
        #1;
        chk("rst_out_valid", {{(W-1){1'b0}}, out_valid}, '0);
        do_reset();
        chk("rst_out_last", {{(W-1){1'b0}}, out_last}, '0);
        chk("rst_out_data", out_data, '0);
        chk("rst_in_ready", {{(W-1){1'b0}}, in_ready}, {{(W-1){1'b0}}, 1'b1});

        // Directed table: a single beat per entry, with the latency and the one-cycle valid pulse checked.
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            in_data    = splat(tbl[i].dr, tbl[i].di);
            coeff_data = splat(tbl[i].cr, tbl[i].ci);
            in_valid   = 1'b1;
            out_ready  = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            chk({tbl[i].nm, "_lat1"}, {{(W-1){1'b0}}, out_valid}, '0);
            @(posedge clk); #1;
            chk({tbl[i].nm, "_vld"}, {{(W-1){1'b0}}, out_valid}, {{(W-1){1'b0}}, 1'b1});
            chk({tbl[i].nm, "_data"}, out_data, splat(tbl[i].er, tbl[i].ei));
            @(posedge clk); #1;
            chk({tbl[i].nm, "_pulse"}, {{(W-1){1'b0}}, out_valid}, '0);
        end

        // Eight back-to-back beats with a 1,0,0 repeating out_ready pattern.
        do_reset();
        base = out_cnt;
        sent = 0;
        for (cyc = 0; cyc < 200 && (out_cnt - base) < 8; cyc++) begin
            @(posedge clk); #1;
            out_ready  = (cyc % 3 == 0);
            in_valid   = (sent < 8);
            in_data    = rand_bus();
            coeff_data = rand_bus();
            #1;
            acc = in_valid && in_ready;
            if (acc) sent++;
        end
        chk("b2b_count", W'(out_cnt - base), W'(8));

        // Reset mid-frame with two beats stalled in the pipe.
        @(posedge clk); #1;
        out_ready = 1'b0;
        sent = 0;
        for (cyc = 0; cyc < 20 && sent < 2; cyc++) begin
            in_valid   = 1'b1;
            in_data    = rand_bus();
            coeff_data = rand_bus();
            #1;
            acc = in_valid && in_ready;
            if (acc) sent++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("mid_two_accepted", W'(sent), W'(2));
        rst = 1'b1;
        exp_q.delete();
        out_idx = 0;
        #1;
        chk("mid_rst_valid_now", {{(W-1){1'b0}}, out_valid}, '0);
        @(posedge clk); #1;
        chk("mid_rst_valid_next", {{(W-1){1'b0}}, out_valid}, '0);
        chk("mid_rst_data", out_data, '0);
        rst = 1'b0;
        out_ready = 1'b1;
        base = out_cnt;
        sent = 0;
        for (cyc = 0; cyc < 50 && (out_cnt - base) < 4; cyc++) begin
            @(posedge clk); #1;
            in_valid   = (sent < 4);
            in_data    = rand_bus();
            coeff_data = rand_bus();
            #1;
            acc = in_valid && in_ready;
            if (acc) sent++;
        end
        chk("mid_frame_count", W'(out_cnt - base), W'(4));

        // Randomized traffic with random bubbles and backpressure.
        for (cyc = 0; cyc < 400; cyc++) begin
            @(posedge clk); #1;
            in_valid   = ($urandom_range(0, 9) < 7);
            out_ready  = ($urandom_range(0, 9) < 6);
            in_data    = rand_bus();
            coeff_data = rand_bus();
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (cyc = 0; cyc < 50 && exp_q.size() > 0; cyc++) @(posedge clk);
        #1;
        chk("drain_empty", W'(exp_q.size()), '0);
        chk("drain_idle", {{(W-1){1'b0}}, out_valid}, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
